alu_req_sched: RTL and testbench
================================

Name: alu_req_sched

Overview:
- Sequencer and 2-way arbiter that shares one 18-bit add/sub/mul/div ALU between two requesters.
- Accepts one operation at a time over a valid/ready handshake. Round-robin selects the requester.
- Drives the ALU operand and select lines, waits a per-operation latency, captures the result and returns it on a response handshake.
- Sits between the calculator front-end command sources and the combinational ALU.

Parameters:
- W, 18: operand/result width.
- ADDSUB_LAT, 1: cycles operands are held on the ALU before sampling an add/sub result (≥1).
- MUL_LAT, 2: same for multiply (≥1).
- DIV_LAT, 4: same for divide (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req0_x  in  W  operand x.
- req0_y  in  W  operand y.
- req1_valid, req1_ready, req1_op, req1_x, req1_y: same as requester 0, for requester 1.
- alu_x  out  W  registered operand x to the ALU.
- alu_y  out  W  registered operand y to the ALU.
- alu_s  out  2  registered ALU select (same encoding as op).
- alu_z  in  W  ALU result.
- alu_v  in  1  ALU add/sub overflow.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that issued the operation.
- rsp_z  out  W  result.
- rsp_v  out  1  overflow; alu_v for add/sub, forced 0 for mul/div.
- rsp_err  out  1  divide by zero.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state=IDLE; rr pointer=0, so requester 0 has priority.
  - alu_x=0, alu_y=0, alu_s=0.
  - rsp_valid=0, rsp_id=0, rsp_z=0, rsp_v=0, rsp_err=0; counter=0.
  - Any in-flight operation is discarded and produces no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, it goes to the one not granted last; the pointer starts at 0 after reset.
  - reqN_ready is combinational: state==IDLE && !rst && grant==N. At most one ready is high per cycle.
  - On accept (valid&&ready) in cycle T:
    - Register x/y/op into alu_x/alu_y/alu_s and the requester id into rsp_id.
    - Toggle the rr pointer to the other requester.
    - Load counter = LAT(op)-1 and go to EXEC.
  - Exception, op==11 with y==0: go straight to RESP with rsp_z={W{1'b1}}, rsp_err=1, rsp_v=0. The ALU is not driven with the new operands; alu_* keep their old values.
  - If no request is valid, stay in IDLE.
- EXEC:
  - alu_* are stable during cycles T+1..T+LAT.
  - When counter==0, capture rsp_z=alu_z and rsp_v=(alu_s[1]?0:alu_v), set rsp_err=0, and go to RESP. Otherwise decrement the counter.
  - rsp_valid therefore rises in cycle T+LAT+1, or T+1 for divide by zero.
  - Requester valid/data changes during EXEC are ignored.
- RESP:
  - rsp_valid=1; rsp_* and alu_* are held stable.
  - On rsp_ready=1, go to IDLE. No accept happens in the same cycle, so there is a one-cycle bubble; the minimum issue interval is LAT+2 cycles.
  - rsp_ready may be held low indefinitely.
- alu_* hold their last values after completion; they are not cleared.
- Width rules:
  - Mul/div results are the low W bits from the ALU; no overflow is reported for them.
  - The counter width is clog2(max(ADDSUB_LAT,MUL_LAT,DIV_LAT)).
- A requester deasserting valid before ready is legal; no accept occurs.

Decomposition:
- Package alu_sched_pkg:
  - W constant.
  - op codes OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - state enum IDLE/EXEC/RESP.
  - latency-lookup function.
- Sub-module rr_arb2: 2-request round-robin grant.
  - Inputs: req[1:0], pointer.
  - Outputs: one-hot gnt, gnt_id.
  - Purely combinational; the pointer register lives in the parent.

Test Plan:
- Reset: hold rst 2 cycles with both valid high → req*_ready=0, rsp_valid=0, busy=0, alu_x/y/s=0. After release, req0_ready=1 in the first cycle.
- Add: req0 op=00 x=5 y=7 accepted at T → alu_x=5, alu_y=7, alu_s=00 at T+1; rsp_valid at T+2 with rsp_z=12, rsp_id=0, rsp_v=0, rsp_err=0.
- Arbitration: req0 and req1 both valid continuously, req0 op=10 x=3 y=4, req1 op=01 x=10 y=3, rsp_ready=1 → responses in order id0 (z=12, at T+3), then id1 (z=7). A third grant goes to req0.
- Divide by zero: req1 op=11 x=100 y=0 accepted at T → rsp_valid at T+1 with rsp_z=0x3FFFF, rsp_err=1, rsp_id=1; alu_* unchanged.
- Backpressure: div x=100 y=7 with rsp_ready=0 for 5 cycles → rsp_valid stays 1 with rsp_z=14 stable, req*_ready=0 throughout. After rsp_ready=1, the next accept is no earlier than the following cycle.
- Reset mid-EXEC: mul accepted, rst asserted at T+1 → no rsp_valid ever for that operation; all outputs at reset values at the next edge.

Source files
------------

// File: rtl/alu_sched_pkg.sv
// Shared constants, op encodings, FSM states and latency lookup for the ALU request scheduler.
package alu_sched_pkg;

    localparam int W = 18;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    // Number of cycles the operands must sit on the ALU before its result is valid.
    function automatic int unsigned op_latency(input logic [1:0] op,
                                               input int unsigned addsub_lat,
                                               input int unsigned mul_lat,
                                               input int unsigned div_lat);
        case (op)
            OP_MUL:  return mul_lat;
            OP_DIV:  return div_lat;
            default: return addsub_lat;
        endcase
    endfunction

endpackage

// File: rtl/alu_req_sched_rr_arb2.sv
// Two-requester round-robin grant; the priority pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // A lone requester always wins; on contention the pointer names the winner.
    always_comb begin
        gnt_id = 1'b0;
        gnt    = 2'b00;
        case (req)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ptr;
            default: gnt_id = 1'b0;
        endcase
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one combinational add/sub/mul/div ALU between two requesters: arbitrates,
// holds operands for the op latency, captures the result and returns it on a response handshake.
module alu_req_sched #(
    parameter int W          = alu_sched_pkg::W,
    parameter int ADDSUB_LAT = 1,
    parameter int MUL_LAT    = 2,
    parameter int DIV_LAT    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_x,
    input  logic [W-1:0] req0_y,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_x,
    input  logic [W-1:0] req1_y,
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    output logic [1:0]   alu_s,
    input  logic [W-1:0] alu_z,
    input  logic         alu_v,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_z,
    output logic         rsp_v,
    output logic         rsp_err,
    output logic         busy
);
    import alu_sched_pkg::*;

    localparam int MAX_AM  = (ADDSUB_LAT > MUL_LAT) ? ADDSUB_LAT : MUL_LAT;
    localparam int MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t         state, state_nxt;
    logic           rr_ptr;
    logic [CW-1:0]  cnt;
    logic [1:0]     req_vec;
    logic [1:0]     gnt;
    logic           gnt_id;
    logic           accept;
    logic [1:0]     sel_op;
    logic [W-1:0]   sel_x;
    logic [W-1:0]   sel_y;
    logic           div_zero;

    assign req_vec = {req1_valid, req0_valid};

    rr_arb2 u_arb (
        .req    (req_vec),
        .ptr    (rr_ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req0_ready = (state == IDLE) && !rst && gnt[0];
    assign req1_ready = (state == IDLE) && !rst && gnt[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign sel_op   = gnt_id ? req1_op : req0_op;
    assign sel_x    = gnt_id ? req1_x  : req0_x;
    assign sel_y    = gnt_id ? req1_y  : req0_y;
    assign div_zero = (sel_op == OP_DIV) && (sel_y == '0);

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: divide by zero skips EXEC since the ALU is never consulted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = div_zero ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the granted operation, count down the latency, capture the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= 1'b0;
            cnt     <= '0;
            alu_x   <= '0;
            alu_y   <= '0;
            alu_s   <= 2'b00;
            rsp_id  <= 1'b0;
            rsp_z   <= '0;
            rsp_v   <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr <= ~gnt_id;
                        rsp_id <= gnt_id;
                        if (div_zero) begin
                            rsp_z   <= {W{1'b1}};
                            rsp_err <= 1'b1;
                            rsp_v   <= 1'b0;
                        end else begin
                            alu_x <= sel_x;
                            alu_y <= sel_y;
                            alu_s <= sel_op;
                            cnt   <= CW'(op_latency(sel_op, ADDSUB_LAT, MUL_LAT, DIV_LAT) - 1);
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_z   <= alu_z;
                        rsp_v   <= alu_s[1] ? 1'b0 : alu_v;
                        rsp_err <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed self-checking bench for alu_req_sched with a behavioural ALU attached.
module tb_alu_req_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [17:0] req0_x, req0_y, req1_x, req1_y;
    logic [17:0] alu_x, alu_y, alu_z;
    logic [1:0]  alu_s;
    logic        alu_v;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_v, rsp_err, busy;
    logic [17:0] rsp_z;
    logic [35:0] prod;

    int test_count = 0;
    int fail_count = 0;

    alu_req_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_s      (alu_s),
        .alu_z      (alu_z),
        .alu_v      (alu_v),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z      (rsp_z),
        .rsp_v      (rsp_v),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural ALU; its overflow flag reads 1 for mul/div so the scheduler's masking is visible.
    always_comb begin
        prod  = 36'(alu_x) * 36'(alu_y);
        alu_z = '0;
        alu_v = 1'b1;
        case (alu_s)
            2'b00: begin
                alu_z = alu_x + alu_y;
                alu_v = (alu_x[17] == alu_y[17]) && (alu_z[17] != alu_x[17]);
            end
            2'b01: begin
                alu_z = alu_x - alu_y;
                alu_v = (alu_x[17] != alu_y[17]) && (alu_z[17] != alu_x[17]);
            end
            2'b10: alu_z = prod[17:0];
            default: alu_z = (alu_y == '0) ? '1 : alu_x / alu_y;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r,
                                 input logic v0, input logic [1:0] o0, input logic [17:0] x0, input logic [17:0] y0,
                                 input logic v1, input logic [1:0] o1, input logic [17:0] x1, input logic [17:0] y1,
                                 input logic rr);
        rst        = r;
        req0_valid = v0;
        req0_op    = o0;
        req0_x     = x0;
        req0_y     = y0;
        req1_valid = v1;
        req1_op    = o1;
        req1_x     = x1;
        req1_y     = y1;
        rsp_ready  = rr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset with both requesters asserting valid.
        applyStimulus(1, 1, 2'b00, 18'd5, 18'd7, 1, 2'b01, 18'd10, 18'd3, 1);
        tick();
        tick();
        checkOutput("rst_ready0", 32'(req0_ready), 0);
        checkOutput("rst_ready1", 32'(req1_ready), 0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_alu_x", 32'(alu_x), 0);
        checkOutput("rst_alu_y", 32'(alu_y), 0);
        checkOutput("rst_alu_s", 32'(alu_s), 0);
        checkOutput("rst_rsp_z", 32'(rsp_z), 0);

        // Release: requester 0 has priority and its add is accepted.
        applyStimulus(0, 1, 2'b00, 18'd5, 18'd7, 1, 2'b01, 18'd10, 18'd3, 1);
        checkOutput("rel_ready0", 32'(req0_ready), 1);
        checkOutput("rel_ready1", 32'(req1_ready), 0);
        tick();
        applyStimulus(0, 1, 2'b00, 18'd5, 18'd7, 0, 2'b01, 18'd10, 18'd3, 1);
        checkOutput("add_alu_x", 32'(alu_x), 5);
        checkOutput("add_alu_y", 32'(alu_y), 7);
        checkOutput("add_alu_s", 32'(alu_s), 0);
        checkOutput("add_busy", 32'(busy), 1);
        checkOutput("add_rsp_valid_early", 32'(rsp_valid), 0);
        checkOutput("add_ready0_exec", 32'(req0_ready), 0);
        tick();
        applyStimulus(0, 0, 2'b00, 18'd0, 18'd0, 0, 2'b00, 18'd0, 18'd0, 1);
        checkOutput("add_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("add_rsp_z", 32'(rsp_z), 12);
        checkOutput("add_rsp_id", 32'(rsp_id), 0);
        checkOutput("add_rsp_v", 32'(rsp_v), 0);
        checkOutput("add_rsp_err", 32'(rsp_err), 0);
        tick();
        checkOutput("add_idle_busy", 32'(busy), 0);
        checkOutput("add_idle_rsp_valid", 32'(rsp_valid), 0);

        // Divide by zero from requester 1 goes straight to a response.
        applyStimulus(0, 0, 2'b00, 18'd0, 18'd0, 1, 2'b11, 18'd100, 18'd0, 0);
        checkOutput("dz_ready1", 32'(req1_ready), 1);
        checkOutput("dz_ready0", 32'(req0_ready), 0);
        tick();
        applyStimulus(0, 0, 2'b00, 18'd0, 18'd0, 0, 2'b11, 18'd100, 18'd0, 0);
        checkOutput("dz_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("dz_rsp_z", 32'(rsp_z), 32'h3FFFF);
        checkOutput("dz_rsp_err", 32'(rsp_err), 1);
        checkOutput("dz_rsp_id", 32'(rsp_id), 1);
        checkOutput("dz_rsp_v", 32'(rsp_v), 0);
        checkOutput("dz_alu_x", 32'(alu_x), 5);
        checkOutput("dz_alu_y", 32'(alu_y), 7);
        checkOutput("dz_alu_s", 32'(alu_s), 0);
        applyStimulus(0, 0, 2'b00, 18'd0, 18'd0, 0, 2'b11, 18'd100, 18'd0, 1);
        tick();
        checkOutput("dz_idle", 32'(busy), 0);

        // Contention: mul from req0 first, then sub from req1, then req0 again.
        applyStimulus(0, 1, 2'b10, 18'd3, 18'd4, 1, 2'b01, 18'd10, 18'd3, 1);
        checkOutput("arb1_ready0", 32'(req0_ready), 1);
        checkOutput("arb1_ready1", 32'(req1_ready), 0);
        tick();
        checkOutput("arb1_alu_s", 32'(alu_s), 2);
        checkOutput("arb1_alu_x", 32'(alu_x), 3);
        tick();
        checkOutput("arb1_rsp_valid_t2", 32'(rsp_valid), 0);
        tick();
        checkOutput("arb1_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("arb1_rsp_z", 32'(rsp_z), 12);
        checkOutput("arb1_rsp_id", 32'(rsp_id), 0);
        checkOutput("arb1_rsp_v", 32'(rsp_v), 0);
        tick();
        checkOutput("arb2_ready1", 32'(req1_ready), 1);
        checkOutput("arb2_ready0", 32'(req0_ready), 0);
        tick();
        checkOutput("arb2_alu_s", 32'(alu_s), 1);
        checkOutput("arb2_alu_x", 32'(alu_x), 10);
        checkOutput("arb2_alu_y", 32'(alu_y), 3);
        tick();
        checkOutput("arb2_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("arb2_rsp_z", 32'(rsp_z), 7);
        checkOutput("arb2_rsp_id", 32'(rsp_id), 1);
        checkOutput("arb2_rsp_v", 32'(rsp_v), 0);
        tick();
        checkOutput("arb3_ready0", 32'(req0_ready), 1);
        checkOutput("arb3_ready1", 32'(req1_ready), 0);
        applyStimulus(0, 0, 2'b10, 18'd3, 18'd4, 0, 2'b01, 18'd10, 18'd3, 0);
        tick();
        checkOutput("withdraw_busy", 32'(busy), 0);

        // Backpressure on a real divide while requester 1 keeps asking.
        applyStimulus(0, 1, 2'b11, 18'd100, 18'd7, 0, 2'b00, 18'd1, 18'd2, 0);
        checkOutput("bp_ready0", 32'(req0_ready), 1);
        tick();
        applyStimulus(0, 0, 2'b11, 18'd100, 18'd7, 1, 2'b00, 18'd1, 18'd2, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("bp_exec_valid_%0d", i), 32'(rsp_valid), 0);
            checkOutput($sformatf("bp_exec_ready1_%0d", i), 32'(req1_ready), 0);
            tick();
        end
        checkOutput("bp_rsp_valid", 32'(rsp_valid), 1);
        checkOutput("bp_rsp_z", 32'(rsp_z), 14);
        checkOutput("bp_rsp_id", 32'(rsp_id), 0);
        checkOutput("bp_rsp_err", 32'(rsp_err), 0);
        checkOutput("bp_rsp_v", 32'(rsp_v), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(rsp_valid), 1);
            checkOutput($sformatf("bp_hold_z_%0d", i), 32'(rsp_z), 14);
            checkOutput($sformatf("bp_hold_ready1_%0d", i), 32'(req1_ready), 0);
        end
        applyStimulus(0, 0, 2'b11, 18'd100, 18'd7, 1, 2'b00, 18'd1, 18'd2, 1);
        checkOutput("bp_release_ready1", 32'(req1_ready), 0);
        tick();
        checkOutput("bp_bubble_ready1", 32'(req1_ready), 1);
        tick();
        applyStimulus(0, 0, 2'b00, 18'd0, 18'd0, 0, 2'b00, 18'd1, 18'd2, 1);
        checkOutput("bp_next_alu_x", 32'(alu_x), 1);
        checkOutput("bp_next_alu_y", 32'(alu_y), 2);
        tick();
        checkOutput("bp_next_rsp_z", 32'(rsp_z), 3);
        checkOutput("bp_next_rsp_id", 32'(rsp_id), 1);
        tick();

        // Signed overflow on add is reported.
        applyStimulus(0, 1, 2'b00, 18'h1FFFF, 18'd1, 0, 2'b00, 18'd0, 18'd0, 1);
        checkOutput("ovf_ready0", 32'(req0_ready), 1);
        tick();
        applyStimulus(0, 0, 2'b00, 18'h1FFFF, 18'd1, 0, 2'b00, 18'd0, 18'd0, 1);
        tick();
        checkOutput("ovf_rsp_z", 32'(rsp_z), 32'h20000);
        checkOutput("ovf_rsp_v", 32'(rsp_v), 1);
        tick();

        // Reset during EXEC discards the multiply.
        applyStimulus(0, 1, 2'b10, 18'd3, 18'd5, 0, 2'b00, 18'd0, 18'd0, 1);
        tick();
        applyStimulus(1, 0, 2'b10, 18'd3, 18'd5, 0, 2'b00, 18'd0, 18'd0, 1);
        checkOutput("mrst_alu_x_before", 32'(alu_x), 3);
        checkOutput("mrst_ready0", 32'(req0_ready), 0);
        tick();
        checkOutput("mrst_busy", 32'(busy), 0);
        checkOutput("mrst_rsp_valid", 32'(rsp_valid), 0);
        checkOutput("mrst_alu_x", 32'(alu_x), 0);
        checkOutput("mrst_alu_y", 32'(alu_y), 0);
        checkOutput("mrst_alu_s", 32'(alu_s), 0);
        checkOutput("mrst_rsp_z", 32'(rsp_z), 0);
        checkOutput("mrst_rsp_v", 32'(rsp_v), 0);
        checkOutput("mrst_rsp_id", 32'(rsp_id), 0);
        applyStimulus(0, 0, 2'b00, 18'd0, 18'd0, 0, 2'b00, 18'd0, 18'd0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("mrst_no_rsp_%0d", i), 32'(rsp_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
